axil_reg_slave: RTL

AXI-Lite responder that terminates one slave port of the AXI-Lite interconnect with a bank of software-visible 32-bit registers. It accepts AW/W/B and AR/R transactions independently, applies byte strobes, reports out-of-range accesses with SLVERR, and exposes register contents and per-register write pulses to user logic. It sits on one `m_axil[i]` leg of the interconnect.

---
 rtl/axil_pkg.sv | 11 +
 rtl/axil_if.sv | 42 ++++
 rtl/axil_reg_slave.sv | 139 +++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// AXI-Lite response codes shared by the register slave
// and the interconnect's invalid-address responders.
package axil_pkg;

    typedef logic [1:0] axil_resp_t;

    localparam axil_resp_t RESP_OKAY   = 2'b00;
    localparam axil_resp_t RESP_SLVERR = 2'b10;
    localparam axil_resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_if.sv
// AXI-Lite bundle: aw, w, b, ar and r channels with
// master and slave views.
interface axil_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic [ADDR_W-1:0]     awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wvalid;
    logic                  wready;
    axil_pkg::axil_resp_t  bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_W-1:0]     araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_W-1:0]     rdata;
    axil_pkg::axil_resp_t  rresp;
    logic                  rvalid;
    logic                  rready;

    modport s_axil (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

    modport m_axil (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

endinterface

// File: rtl/axil_reg_slave.sv
// AXI-Lite register bank: independent AW/W capture slots with
// byte strobes, registered read path, SLVERR on out-of-range.
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int                    NUM_REGS       = 16,
    parameter int                    AXI_DATA_WIDTH = 32,
    parameter int                    AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_DATA_WIDTH-1:0] RESET_VALUE = 32'h0
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    axil_if.s_axil                   s_axil,
    output logic [NUM_REGS-1:0][AXI_DATA_WIDTH-1:0] regs,
    output logic [NUM_REGS-1:0]      reg_wr_stb
);

    localparam int LOG2 = $clog2(NUM_REGS);
    localparam int IW   = (LOG2 > 0) ? LOG2 : 1;
    localparam int NB   = AXI_DATA_WIDTH / 8;

    typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;

    function automatic logic [IW-1:0] f_idx(input addr_t a);
        return (NUM_REGS == 1) ? '0 : IW'(a >> 2);
    endfunction

    function automatic logic f_in_range(input addr_t a);
        return (a >> (LOG2 + 2)) == '0;
    endfunction

    logic                      r_aw_held;
    addr_t                     r_awaddr;
    logic                      r_w_held;
    logic [AXI_DATA_WIDTH-1:0] r_wdata;
    logic [NB-1:0]             r_wstrb;
    logic                      r_bvalid;
    axil_resp_t                r_bresp;
    logic                      r_rvalid;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    axil_resp_t                r_rresp;

    logic                      w_aw_hs;
    logic                      w_w_hs;
    logic                      w_ar_hs;
    logic                      w_commit;
    addr_t                     w_waddr;
    logic [AXI_DATA_WIDTH-1:0] w_wdata;
    logic [NB-1:0]             w_wstrb;
    logic [IW-1:0]             w_widx;
    logic                      w_win;
    logic [IW-1:0]             w_ridx;
    logic                      w_rin;

    assign s_axil.awready = aresetn & ~r_aw_held & ~r_bvalid;
    assign s_axil.wready  = aresetn & ~r_w_held & ~r_bvalid;
    assign s_axil.arready = aresetn & ~r_rvalid;
    assign s_axil.bvalid  = r_bvalid;
    assign s_axil.bresp   = r_bresp;
    assign s_axil.rvalid  = r_rvalid;
    assign s_axil.rdata   = r_rdata;
    assign s_axil.rresp   = r_rresp;

    assign w_aw_hs  = s_axil.awvalid & s_axil.awready;
    assign w_w_hs   = s_axil.wvalid & s_axil.wready;
    assign w_ar_hs  = s_axil.arvalid & s_axil.arready;
    assign w_commit = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);

    // A held beat takes priority; the live bus is used otherwise.
    assign w_waddr = r_aw_held ? r_awaddr : s_axil.awaddr;
    assign w_wdata = r_w_held ? r_wdata : s_axil.wdata;
    assign w_wstrb = r_w_held ? r_wstrb : s_axil.wstrb;
    assign w_widx  = f_idx(w_waddr);
    assign w_win   = f_in_range(w_waddr);
    assign w_ridx  = f_idx(s_axil.araddr);
    assign w_rin   = f_in_range(s_axil.araddr);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            regs       <= {NUM_REGS{RESET_VALUE}};
            reg_wr_stb <= '0;
            r_aw_held  <= 1'b0;
            r_awaddr   <= '0;
            r_w_held   <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else begin
            reg_wr_stb <= '0;
            if (r_bvalid && s_axil.bready) begin
                r_bvalid <= 1'b0;
            end
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_win ? RESP_OKAY : RESP_SLVERR;
                if (w_win) begin
                    reg_wr_stb[w_widx] <= 1'b1;
                    for (int k = 0; k < NB; k++) begin
                        if (w_wstrb[k]) begin
                            regs[w_widx][8*k +: 8] <= w_wdata[8*k +: 8];
                        end
                    end
                end
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_awaddr  <= s_axil.awaddr;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= s_axil.wdata;
                    r_wstrb  <= s_axil.wstrb;
                end
            end
        end
    end

    // Reads sample regs before any same-edge write lands.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            if (r_rvalid && s_axil.rready) begin
                r_rvalid <= 1'b0;
            end
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rin ? regs[w_ridx] : '0;
                r_rresp  <= w_rin ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule
